timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped timer that sits downstream of the CPU's data-bus bridge and upstream of the CP0 interrupt input. It holds CTRL/PRESET/COUNT registers that the CPU writes with byte enables, counts PRESET down to zero, and raises `irq` as a hardware interrupt source. In mode 0 `irq` is held until software acknowledges it. In mode 1 `irq` is a one-cycle pulse and the counter reloads.

## Interface
- `BASE`, default 32'h0000_7F00: base address; the block decodes a 16-byte window `BASE..BASE+15`.
- `clk` in 1: the only clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low (asserted when 0); clears all state immediately.
- `addr` in 32: byte address from the bridge; bits [1:0] are ignored.
- `byteen` in 4: per-byte write enables; a write occurs when `byteen != 0` and `addr` hits.
- `wdata` in 32: write data, byte lanes aligned to `byteen`.
- `rdata` out 32: combinational read data for `addr`; 0 when there is no hit.
- `irq` out 1: interrupt request to CP0.

## Operation
- Registers:
  - CTRL at offset 0x0: [0] EN, [2:1] MODE, [3] IM; bits [31:4] read as 0 and ignore writes.
  - PRESET at offset 0x4: 32-bit, read/write.
  - COUNT at offset 0x8: read-only; writes are ignored.
  - Offset 0xC reads 0 and ignores writes.
- Writes merge per byte: only lanes with `byteen[i]=1` change.
- Hit condition: `addr[31:4] == BASE[31:4]`.
- MODE 2 and 3 behave as mode 0.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if EN=0, go to IDLE (COUNT holds). Else if COUNT > 1, COUNT <= COUNT-1. Else COUNT <= 0, INTFLAG <= 1, go to INT.
  - INT, mode 0: EN <= 0, go to IDLE; INTFLAG stays set.
  - INT, mode 1: INTFLAG <= 0, go to IDLE. EN is still 1, so the counter auto-reloads.
- `irq = IM & INTFLAG`.
- In mode 0, INTFLAG is cleared by any CPU write to CTRL or PRESET.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle as the INT-state EN clear: the CPU write wins.
  - A CPU write clearing INTFLAG in the same cycle the FSM enters INT: set wins.
  - A PRESET write during CNT takes effect at the next LOAD only.
  - Writing EN=0 during CNT stops counting on the next edge. Re-enabling restarts from LOAD, not from the held COUNT.
- PRESET=0: LOAD gives COUNT=0; the first CNT cycle goes to INT (same path as COUNT=1).
- Reset mid-operation: state IDLE, all registers 0, and `irq` drops without waiting for a clock.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, INTFLAG=0, state IDLE, `irq`=0. `rdata` is 0 for every address after reset.
- `rdata` has zero latency: it reflects register values before the next edge.
- A register write is visible in `rdata` in the cycle after its edge.
- With EN set at edge E0 and PRESET=P≥1:
  - State is LOAD after E0+1.
  - COUNT=P after E0+2.
  - COUNT=P-k after E0+2+k, for k < P.
  - COUNT=0, state INT, and `irq` high (if IM=1) after E0+P+2.
- Mode 0: `irq` stays high from E0+P+2 until the edge of an acknowledging CTRL/PRESET write; EN reads 0 after E0+P+3.
- Mode 1:
  - `irq` is high for exactly one cycle (E0+P+2 to E0+P+3).
  - Reload gives COUNT=P after E0+P+5.
  - Period is P+3 cycles.
- PRESET=0 behaves as PRESET=1: INT after E0+3.

## Test plan
- Reset/readback: hold `reset`=0 mid-count with `irq` high → `irq` and `rdata` are 0 asynchronously. Release, write PRESET=0x12345678 with byteen=4'b0011 → PRESET reads 0x00005678.
- Mode 0 one-shot: PRESET=5, CTRL=0x9 (IM=1, mode 0, EN=1) at E0 → COUNT sequence 5,4,3,2,1,0. `irq` rises after E0+7, CTRL reads 0x8 after E0+8, and `irq` is held until a write of CTRL=0x8, then falls after that edge.
- Mode 1 periodic: PRESET=3, CTRL=0xB → `irq` pulses 1 cycle wide, every 6 cycles, for 3 periods; COUNT reloads to 3 each time.
- Masking and stop: CTRL=0x1 (IM=0), PRESET=2 → COUNT reaches 0 and `irq` stays 0. Separately, write EN=0 mid-count at COUNT=4 → COUNT holds at 4, and re-enabling reloads PRESET.
- Boundaries: PRESET=0 → `irq` after E0+3. PRESET written to 10 during a count from 3 → current run ends at 0, next mode 1 run loads 10. Write to COUNT offset → no change.
- Decode: write to BASE+0x10 or BASE-4 → no register change and `rdata`=0. Read BASE+0xC → 0.

Source files
------------

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers and an
// interrupt output for CP0. Mode 0 holds irq until acknowledged by a CTRL or
// PRESET write; mode 1 pulses irq for one cycle and reloads automatically.
module timer_counter #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  state_t      state_next;

  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        int_flag;

  logic        hit;
  logic [3:0]  offset;
  logic        wr_any;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        mode_periodic;

  logic        load_count;
  logic        dec_count;
  logic        reach_zero;
  logic        int_stop;
  logic        int_rearm;

  // Lane-wise merge: only byte lanes with their enable set take new data.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end
    end
    return res;
  endfunction

  // The two low address bits are masked off so word offsets ignore them.
  assign hit           = (addr[31:4] == BASE[31:4]);
  assign offset        = addr[3:0] & 4'hC;
  assign wr_any        = hit && (byteen != 4'b0000);
  assign wr_ctrl       = wr_any && (offset == 4'h0);
  assign wr_preset     = wr_any && (offset == 4'h4);
  assign mode_periodic = (ctrl_mode == 2'd1);

  assign irq = ctrl_im & int_flag;

  // Combinational read mux; anything outside the window reads as zero.
  always_comb begin
    rdata = 32'h0;
    if (hit) begin
      case (offset)
        4'h0:    rdata = {28'h0, ctrl_im, ctrl_mode, ctrl_en};
        4'h4:    rdata = preset;
        4'h8:    rdata = count;
        default: rdata = 32'h0;
      endcase
    end
  end

  // State register for the count sequencer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus one-cycle strobes that drive the datapath below.
  always_comb begin
    state_next = state;
    load_count = 1'b0;
    dec_count  = 1'b0;
    reach_zero = 1'b0;
    int_stop   = 1'b0;
    int_rearm  = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_en) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        load_count = 1'b1;
        state_next = CNT;
      end
      CNT: begin
        if (!ctrl_en) begin
          state_next = IDLE;
        end else if (count > 32'd1) begin
          dec_count = 1'b1;
        end else begin
          reach_zero = 1'b1;
          state_next = INT;
        end
      end
      INT: begin
        if (mode_periodic) begin
          int_rearm = 1'b1;
        end else begin
          int_stop = 1'b1;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // CTRL register: a CPU write to lane 0 overrides the one-shot EN clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'd0;
      ctrl_im   <= 1'b0;
    end else if (wr_ctrl && byteen[0]) begin
      ctrl_en   <= wdata[0];
      ctrl_mode <= wdata[2:1];
      ctrl_im   <= wdata[3];
    end else if (int_stop) begin
      ctrl_en   <= 1'b0;
    end
  end

  // PRESET register; a new value is only picked up by the next LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preset <= 32'h0;
    end else if (wr_preset) begin
      preset <= merge_bytes(preset, wdata, byteen);
    end
  end

  // COUNT register is driven by the sequencer only; bus writes never touch it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 32'h0;
    end else if (load_count) begin
      count <= preset;
    end else if (dec_count) begin
      count <= count - 32'd1;
    end else if (reach_zero) begin
      count <= 32'h0;
    end
  end

  // Interrupt flag: setting on expiry beats a same-cycle software acknowledge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_flag <= 1'b0;
    end else if (reach_zero) begin
      int_flag <= 1'b1;
    end else if (int_rearm) begin
      int_flag <= 1'b0;
    end else if (!mode_periodic && (wr_ctrl || wr_preset)) begin
      int_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: drives bus writes on the falling edge and
// checks registers, COUNT progression and irq against hand-computed values.
module tb_timer_counter;

  localparam logic [31:0] BASE     = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_PRESET = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;
  localparam logic [31:0] A_RSVD   = BASE + 32'hC;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int total;
  int bad;

  timer_counter #(.BASE(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_reg(input string tag, input logic [31:0] a,
                           input logic [31:0] expected);
    addr = a;
    #1;
    check_output(tag, rdata, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One bus write: presented at a falling edge, taken at the next rising edge.
  task automatic apply_stimulus(input logic [31:0] a, input logic [3:0] be,
                                input logic [31:0] d);
    addr   = a;
    byteen = be;
    wdata  = d;
    @(posedge clk);
    @(negedge clk);
    byteen = 4'b0000;
    wdata  = 32'h0;
  endtask

  // Directed sequence, one section per behaviour.
  initial begin
    logic exp_irq;
    total  = 0;
    bad    = 0;
    reset  = 1'b0;
    addr   = 32'h0;
    byteen = 4'b0000;
    wdata  = 32'h0;

    @(negedge clk);
    check_output("rst_irq", {31'h0, irq}, 32'h0);
    check_reg("rst_ctrl", A_CTRL, 32'h0);
    check_reg("rst_preset", A_PRESET, 32'h0);
    check_reg("rst_count", A_COUNT, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check_reg("rst_rsvd", A_RSVD, 32'h0);

    $display("[TB] byte-lane write");
    apply_stimulus(A_PRESET, 4'b0011, 32'h1234_5678);
    check_reg("preset_lanes", A_PRESET, 32'h0000_5678);

    $display("[TB] mode 0 one-shot, PRESET=5");
    apply_stimulus(A_PRESET, 4'b1111, 32'd5);
    apply_stimulus(A_CTRL, 4'b0001, 32'h9);
    check_reg("m0_count_e0", A_COUNT, 32'd0);
    tick();
    tick();
    check_reg("m0_count_5", A_COUNT, 32'd5);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_reg("m0_count_dec", A_COUNT, 32'd5 - 32'(k));
    end
    check_output("m0_irq_pre", {31'h0, irq}, 32'h0);
    tick();
    check_reg("m0_count_0", A_COUNT, 32'd0);
    check_output("m0_irq_rise", {31'h0, irq}, 32'h1);
    tick();
    check_reg("m0_ctrl_en_clr", A_CTRL, 32'h8);
    tick();
    tick();
    check_output("m0_irq_held", {31'h0, irq}, 32'h1);
    apply_stimulus(A_CTRL, 4'b0001, 32'h8);
    check_output("m0_irq_ack", {31'h0, irq}, 32'h0);
    check_reg("m0_ctrl_ack", A_CTRL, 32'h8);

    $display("[TB] mode 1 periodic, PRESET=3");
    apply_stimulus(A_PRESET, 4'b1111, 32'd3);
    apply_stimulus(A_CTRL, 4'b0001, 32'hB);
    for (int t = 1; t <= 18; t++) begin
      tick();
      exp_irq = (t == 5) || (t == 11) || (t == 17);
      check_output("m1_irq", {31'h0, irq}, {31'h0, exp_irq});
      if (t == 2 || t == 8 || t == 14) begin
        check_reg("m1_reload", A_COUNT, 32'd3);
      end
    end
    apply_stimulus(A_CTRL, 4'b0001, 32'h0);
    tick();
    tick();
    tick();

    $display("[TB] masked interrupt, PRESET=2");
    apply_stimulus(A_PRESET, 4'b1111, 32'd2);
    apply_stimulus(A_CTRL, 4'b0001, 32'h1);
    tick();
    tick();
    check_reg("mask_count_2", A_COUNT, 32'd2);
    tick();
    tick();
    check_reg("mask_count_0", A_COUNT, 32'd0);
    check_output("mask_irq", {31'h0, irq}, 32'h0);
    tick();
    check_reg("mask_ctrl", A_CTRL, 32'h0);

    $display("[TB] stop and restart, PRESET=6");
    apply_stimulus(A_PRESET, 4'b1111, 32'd6);
    apply_stimulus(A_CTRL, 4'b0001, 32'h1);
    tick();
    tick();
    tick();
    apply_stimulus(A_CTRL, 4'b0001, 32'h0);
    check_reg("stop_count_4", A_COUNT, 32'd4);
    tick();
    tick();
    check_reg("stop_hold_4", A_COUNT, 32'd4);
    apply_stimulus(A_CTRL, 4'b0001, 32'h1);
    tick();
    tick();
    check_reg("restart_reload", A_COUNT, 32'd6);
    apply_stimulus(A_CTRL, 4'b0001, 32'h0);
    tick();
    tick();

    $display("[TB] PRESET=0 and simultaneous events");
    apply_stimulus(A_PRESET, 4'b1111, 32'd0);
    apply_stimulus(A_CTRL, 4'b0001, 32'h9);
    tick();
    tick();
    check_reg("p0_count", A_COUNT, 32'd0);
    check_output("p0_irq_pre", {31'h0, irq}, 32'h0);
    apply_stimulus(A_PRESET, 4'b1111, 32'd0);
    check_output("p0_set_wins", {31'h0, irq}, 32'h1);
    apply_stimulus(A_CTRL, 4'b0001, 32'h9);
    check_output("p0_ack_irq", {31'h0, irq}, 32'h0);
    check_reg("p0_cpu_wins", A_CTRL, 32'h9);
    tick();
    tick();
    check_output("p0_rerun_pre", {31'h0, irq}, 32'h0);
    tick();
    check_output("p0_rerun_irq", {31'h0, irq}, 32'h1);
    apply_stimulus(A_CTRL, 4'b0001, 32'h8);
    check_output("p0_final_ack", {31'h0, irq}, 32'h0);
    check_reg("p0_final_ctrl", A_CTRL, 32'h8);

    $display("[TB] PRESET change during count");
    apply_stimulus(A_PRESET, 4'b1111, 32'd3);
    apply_stimulus(A_CTRL, 4'b0001, 32'hB);
    tick();
    tick();
    tick();
    apply_stimulus(A_PRESET, 4'b1111, 32'd10);
    check_reg("pchg_count_1", A_COUNT, 32'd1);
    tick();
    check_reg("pchg_end_0", A_COUNT, 32'd0);
    check_output("pchg_irq", {31'h0, irq}, 32'h1);
    tick();
    tick();
    tick();
    check_reg("pchg_reload_10", A_COUNT, 32'd10);
    apply_stimulus(A_CTRL, 4'b0001, 32'h0);
    tick();
    check_reg("pchg_hold_9", A_COUNT, 32'd9);
    apply_stimulus(A_COUNT, 4'b1111, 32'hFFFF_FFFF);
    check_reg("count_ro", A_COUNT, 32'd9);

    $display("[TB] address decode");
    apply_stimulus(BASE + 32'h10, 4'b1111, 32'hFFFF_FFFF);
    apply_stimulus(BASE - 32'h4, 4'b1111, 32'hFFFF_FFFF);
    apply_stimulus(A_RSVD, 4'b1111, 32'hFFFF_FFFF);
    check_reg("dec_ctrl", A_CTRL, 32'h0);
    check_reg("dec_preset", A_PRESET, 32'd10);
    check_reg("dec_count", A_COUNT, 32'd9);
    check_reg("dec_rd_above", BASE + 32'h10, 32'h0);
    check_reg("dec_rd_below", BASE - 32'h4, 32'h0);
    check_reg("dec_rd_rsvd", A_RSVD, 32'h0);
    check_reg("dec_low_bits", BASE + 32'h5, 32'd10);

    $display("[TB] asynchronous reset with irq high");
    apply_stimulus(A_PRESET, 4'b1111, 32'd2);
    apply_stimulus(A_CTRL, 4'b0001, 32'h9);
    tick();
    tick();
    tick();
    tick();
    check_output("ar_irq_high", {31'h0, irq}, 32'h1);
    reset = 1'b0;
    #1;
    check_output("ar_irq_drop", {31'h0, irq}, 32'h0);
    check_reg("ar_ctrl", A_CTRL, 32'h0);
    check_reg("ar_preset", A_PRESET, 32'h0);
    check_reg("ar_count", A_COUNT, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_reg("ar_after", A_CTRL, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
